// File: rtl/mem_wb_pipe_p.sv
// MEM/WB pipeline register with load-data extension, write-back mux and
// saturating stall/flush event counters.
module mem_wb_pipe_p #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] MEM_DATA,
    input  logic [DATA_W-1:0] ALU_VAL,
    input  logic [REG_W-1:0]  REG_DESTINATION,
    input  logic              REGWRITE_IN,
    input  logic              MEM2REG_IN,
    input  logic [1:0]        LOAD_SIZE,
    input  logic              LOAD_SIGNED,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] MEM_DATA_OUT,
    output logic [DATA_W-1:0] ALU_VAL_OUT,
    output logic [REG_W-1:0]  REG_DESTINATION_OUT,
    output logic              REGWRITE_OUT,
    output logic              MEM2REG_OUT,
    output logic [DATA_W-1:0] WB_DATA,
    output logic              WB_EN,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    localparam int unsigned IdxW = $clog2(DATA_W);

    logic              valid_q;
    logic              regwrite_q;
    logic              mem2reg_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] alu_val_q;
    logic [REG_W-1:0]  dest_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic [DATA_W-1:0] load_ext;
    int unsigned       load_width;
    logic [IdxW-1:0]   load_msb;
    logic              load_fill;

    // A word load on a 32-bit datapath is the full width, so no fill bits remain.
    always_comb begin
        load_width = DATA_W;
        unique case (LOAD_SIZE)
            2'b00:   load_width = 8;
            2'b01:   load_width = 16;
            2'b10:   load_width = (DATA_W > 32) ? 32 : DATA_W;
            default: load_width = DATA_W;
        endcase
        load_msb  = IdxW'(load_width - 1);
        load_fill = LOAD_SIGNED & MEM_DATA[load_msb];
        for (int unsigned i = 0; i < DATA_W; i++) begin
            load_ext[i] = (i < load_width) ? MEM_DATA[i] : load_fill;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            mem2reg_q  <= 1'b0;
            mem_data_q <= '0;
            alu_val_q  <= '0;
            dest_q     <= '0;
        end else if (FLUSH) begin
            // Bubble: kill control bits, leave data/destination untouched.
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            mem2reg_q  <= 1'b0;
        end else if (!STALL) begin
            valid_q    <= IN_VALID;
            regwrite_q <= IN_VALID & REGWRITE_IN;
            mem2reg_q  <= IN_VALID & MEM2REG_IN;
            mem_data_q <= load_ext;
            alu_val_q  <= ALU_VAL;
            dest_q     <= REG_DESTINATION;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (FLUSH && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (STALL && !FLUSH && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign OUT_VALID           = valid_q;
    assign REGWRITE_OUT        = regwrite_q;
    assign MEM2REG_OUT         = mem2reg_q;
    assign MEM_DATA_OUT        = mem_data_q;
    assign ALU_VAL_OUT         = alu_val_q;
    assign REG_DESTINATION_OUT = dest_q;
    assign STALL_CNT           = stall_cnt_q;
    assign FLUSH_CNT           = flush_cnt_q;

    assign WB_DATA = mem2reg_q ? mem_data_q : alu_val_q;
    assign WB_EN   = valid_q & regwrite_q & (dest_q != REG_W'(ZERO_REG));

endmodule

// File: tb/tb_mem_wb_pipe_p.sv
// Scoreboard bench for mem_wb_pipe_p: a 64-bit/16-bit-counter instance and a
// 32-bit/4-bit-counter instance share stimulus and are checked together.
module tb_mem_wb_pipe_p;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic [63:0] mem;
        logic [63:0] alu;
        logic [4:0]  dest;
        logic [63:0] wb;
        logic        wb_en;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        logic        valid_s;
        logic [31:0] mem_s;
        logic [31:0] alu_s;
        logic [31:0] wb_s;
        logic        wb_en_s;
        logic [3:0]  scnt_s;
        logic [3:0]  fcnt_s;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, rw, m2r, lsigned;
    logic [63:0] mem_data, alu_val;
    logic [4:0]  dest;
    logic [1:0]  lsize;

    logic        o_valid, o_rw, o_m2r, o_wb_en;
    logic [63:0] o_mem, o_alu, o_wb;
    logic [4:0]  o_dest;
    logic [15:0] o_scnt, o_fcnt;

    logic        s_valid, s_rw, s_m2r, s_wb_en;
    logic [31:0] s_mem, s_alu, s_wb;
    logic [4:0]  s_dest;
    logic [3:0]  s_scnt, s_fcnt;

    // Reference model state
    logic        m_valid, m_rw, m_m2r;
    logic [63:0] m_mem, m_alu;
    logic [4:0]  m_dest;
    logic [15:0] m_scnt, m_fcnt;
    logic [3:0]  m_scnt_s, m_fcnt_s;

    obs_t sb[$];
    obs_t got, exp;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_p #(.DATA_W(64), .REG_W(5), .ZERO_REG(31), .CNT_W(16)) dut (
        .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .IN_VALID(in_valid),
        .MEM_DATA(mem_data), .ALU_VAL(alu_val), .REG_DESTINATION(dest),
        .REGWRITE_IN(rw), .MEM2REG_IN(m2r), .LOAD_SIZE(lsize), .LOAD_SIGNED(lsigned),
        .OUT_VALID(o_valid), .MEM_DATA_OUT(o_mem), .ALU_VAL_OUT(o_alu),
        .REG_DESTINATION_OUT(o_dest), .REGWRITE_OUT(o_rw), .MEM2REG_OUT(o_m2r),
        .WB_DATA(o_wb), .WB_EN(o_wb_en), .STALL_CNT(o_scnt), .FLUSH_CNT(o_fcnt)
    );

    mem_wb_pipe_p #(.DATA_W(32), .REG_W(5), .ZERO_REG(31), .CNT_W(4)) dut_s (
        .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .IN_VALID(in_valid),
        .MEM_DATA(mem_data[31:0]), .ALU_VAL(alu_val[31:0]), .REG_DESTINATION(dest),
        .REGWRITE_IN(rw), .MEM2REG_IN(m2r), .LOAD_SIZE(lsize), .LOAD_SIGNED(lsigned),
        .OUT_VALID(s_valid), .MEM_DATA_OUT(s_mem), .ALU_VAL_OUT(s_alu),
        .REG_DESTINATION_OUT(s_dest), .REGWRITE_OUT(s_rw), .MEM2REG_OUT(s_m2r),
        .WB_DATA(s_wb), .WB_EN(s_wb_en), .STALL_CNT(s_scnt), .FLUSH_CNT(s_fcnt)
    );

    function automatic logic [63:0] ext64(input logic [63:0] d, input logic [1:0] sz,
                                          input logic sg);
        case (sz)
            2'd0:    ext64 = sg ? {{56{d[7]}}, d[7:0]} : {56'h0, d[7:0]};
            2'd1:    ext64 = sg ? {{48{d[15]}}, d[15:0]} : {48'h0, d[15:0]};
            2'd2:    ext64 = sg ? {{32{d[31]}}, d[31:0]} : {32'h0, d[31:0]};
            default: ext64 = d;
        endcase
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o.valid = o_valid;   o.rw = o_rw;       o.m2r = o_m2r;
        o.mem = o_mem;       o.alu = o_alu;     o.dest = o_dest;
        o.wb = o_wb;         o.wb_en = o_wb_en; o.scnt = o_scnt; o.fcnt = o_fcnt;
        o.valid_s = s_valid & s_rw == o_rw & s_m2r == o_m2r & s_dest == o_dest;
        o.mem_s = s_mem;     o.alu_s = s_alu;   o.wb_s = s_wb;   o.wb_en_s = s_wb_en;
        o.scnt_s = s_scnt;   o.fcnt_s = s_fcnt;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.valid = m_valid;   o.rw = m_rw;   o.m2r = m_m2r;
        o.mem = m_mem;       o.alu = m_alu; o.dest = m_dest;
        o.wb = m_m2r ? m_mem : m_alu;
        o.wb_en = m_valid & m_rw & (m_dest != 5'd31);
        o.scnt = m_scnt;     o.fcnt = m_fcnt;
        o.valid_s = m_valid;
        // Narrow instance sees the low half of the same extension.
        o.mem_s = m_mem[31:0];
        o.alu_s = m_alu[31:0];
        o.wb_s = o.wb[31:0];
        o.wb_en_s = o.wb_en;
        o.scnt_s = m_scnt_s; o.fcnt_s = m_fcnt_s;
        return o;
    endfunction

    // Advance the model by one edge using the current inputs, queue the expectation,
    // then clock the DUTs and settle 1 ns past the edge.
    task automatic step();
        if (rst) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_mem = '0; m_alu = '0; m_dest = '0;
            m_scnt = '0; m_fcnt = '0; m_scnt_s = '0; m_fcnt_s = '0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_m2r = 0;
            if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
            if (m_fcnt_s != 4'hF) m_fcnt_s = m_fcnt_s + 4'd1;
        end else if (stall) begin
            if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            if (m_scnt_s != 4'hF) m_scnt_s = m_scnt_s + 4'd1;
        end else begin
            m_valid = in_valid;
            m_rw = in_valid & rw;
            m_m2r = in_valid & m2r;
            m_mem = ext64(mem_data, lsize, lsigned);
            m_alu = alu_val;
            m_dest = dest;
        end
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic l, input logic [4:0] d,
                         input logic [63:0] md, input logic [63:0] av,
                         input logic [1:0] sz, input logic sg);
        in_valid = v; rw = w; m2r = l; dest = d;
        mem_data = md; alu_val = av; lsize = sz; lsigned = sg;
    endtask

    task automatic test_reset();
        rst = 1; stall = 1; flush = 1;
        drive(1, 1, 1, 5'd7, 64'hDEAD_BEEF_0123_4567, 64'h55, 2'd3, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            exp = sb.pop_front(); got = snap(); n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset got=%h exp=%h", got, exp);
            end
        end
        rst = 0; stall = 0; flush = 0;
    endtask

    task automatic test_load_ext();
        logic [63:0] pats [4];
        pats[0] = 64'h0000_0000_0000_00F0;
        pats[1] = 64'h8123_4567_89AB_CDEF;
        pats[2] = 64'h7FFF_FFFF_7FFF_7F7F;
        pats[3] = 64'hFFFF_FFFF_8000_8080;
        for (int p = 0; p < 4; p++) begin
            for (int sz = 0; sz < 4; sz++) begin
                for (int sg = 0; sg < 2; sg++) begin
                    drive(1, 1, 1, 5'd3, pats[p], 64'h1234, 2'(sz), 1'(sg));
                    step();
                    exp = sb.pop_front(); got = snap(); n_vec++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL load_ext p%0d sz%0d sg%0d got=%h exp=%h",
                                 p, sz, sg, got, exp);
                    end
                end
            end
        end
        // Known-answer byte load, signed then unsigned
        drive(1, 1, 1, 5'd3, 64'hF0, 64'h0, 2'd0, 1);
        step();
        void'(sb.pop_front());
        n_vec++;
        if (o_wb !== 64'hFFFF_FFFF_FFFF_FFF0 || o_wb_en !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_signed got=%h/%b exp=fffffffffffffff0/1", o_wb, o_wb_en);
        end
        lsigned = 0;
        step();
        void'(sb.pop_front());
        n_vec++;
        if (o_wb !== 64'hF0 || o_wb_en !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_unsigned got=%h/%b exp=f0/1", o_wb, o_wb_en);
        end
    endtask

    task automatic test_xzr_invalid();
        drive(1, 1, 0, 5'd31, 64'h99, 64'd5, 2'd3, 0);
        step();
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_alu !== 64'd5 || o_wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL xzr alu=%h wb_en=%b exp alu=5 wb_en=0", o_alu, o_wb_en);
        end
        // Invalid entry: control bits drop, data still captured
        drive(0, 1, 1, 5'd9, 64'hABCD, 64'h77, 2'd3, 0);
        step();
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_alu !== 64'h77 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_stall_flush();
        rst = 1; step(); void'(sb.pop_front()); rst = 0;
        drive(1, 1, 0, 5'd4, 64'h0, 64'h11, 2'd3, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front(); got = snap(); n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stall_hold%0d got=%h exp=%h", i, got, exp);
            end
            stall = 1;
            drive(1, 0, 1, 5'(i + 10), 64'($urandom), 64'($urandom), 2'd1, 1);
            step();
        end
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_alu !== 64'h11 || o_scnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stall3 alu=%h scnt=%0d exp alu=11 scnt=3", o_alu, o_scnt);
        end
        flush = 1;
        step();
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_valid !== 1'b0 || o_fcnt !== 16'd1 || o_scnt !== 16'd3) begin
            n_fail++;
            $display("FAIL flush_stall v=%b f=%0d s=%0d exp v=0 f=1 s=3",
                     o_valid, o_fcnt, o_scnt);
        end
        flush = 0; stall = 0;
    endtask

    task automatic test_saturation();
        stall = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = sb.pop_front(); got = snap(); n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stall_sat%0d got=%h exp=%h", i, got, exp);
            end
        end
        n_vec++;
        if (s_scnt !== 4'd15) begin
            n_fail++;
            $display("FAIL stall_sat_final got=%0d exp=15", s_scnt);
        end
        flush = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = sb.pop_front(); got = snap(); n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush_sat%0d got=%h exp=%h", i, got, exp);
            end
        end
        n_vec++;
        if (s_fcnt !== 4'd15 || s_scnt !== 4'd15) begin
            n_fail++;
            $display("FAIL flush_sat_final got=%0d/%0d exp=15/15", s_fcnt, s_scnt);
        end
        flush = 0; stall = 0;
    endtask

    task automatic test_reset_priority();
        drive(1, 1, 0, 5'd6, 64'h0, 64'h42, 2'd3, 0);
        step(); void'(sb.pop_front());
        stall = 1; step(); void'(sb.pop_front());
        rst = 1; flush = 1;
        step();
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_scnt !== 16'd0 || o_alu !== 64'd0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_prio got=%h exp=%h", got, exp);
        end
        rst = 0; flush = 0; stall = 0;
        drive(1, 1, 0, 5'd8, 64'h0, 64'h5A, 2'd3, 0);
        step();
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_alu !== 64'h5A || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset alu=%h v=%b exp alu=5a v=1", o_alu, o_valid);
        end
        // A reset pulse that never overlaps an edge must leave state alone
        rst = 1; #2; rst = 0;
        drive(0, 0, 0, 5'd1, 64'h0, 64'h0, 2'd3, 0);
        stall = 1;
        step();
        exp = sb.pop_front(); got = snap(); n_vec++;
        if (got !== exp || o_alu !== 64'h5A) begin
            n_fail++;
            $display("FAIL reset_between_edges got=%h exp=%h", got, exp);
        end
        stall = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 1'($urandom));
            step();
            exp = sb.pop_front(); got = snap(); n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b%0d got=%h exp=%h", i, got, exp);
            end
        end
        stall = 0; flush = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 5'd0, 64'h0, 64'h0, 2'd0, 0);
        @(posedge clk); #1;
        test_reset();
        test_load_ext();
        test_xzr_invalid();
        test_stall_flush();
        test_saturation();
        test_reset_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
